// File: rtl/delay_timer_ctrl.sv
// ---------------------------------------------------------------------------
// delay_timer_ctrl
//
// Restartable delay timer for the valve/pump sequencer. A start pulse in IDLE
// latches a delay count and a time unit (ms, s, min, hr, day). The timer then
// counts that many units against a prescaler chain and emits a single-cycle
// done pulse. The timer supports:
//   - pause: holds every counter
//   - abort: cancels silently
//   - zero delay: immediate done
//   - invalid unit: single-cycle err pulse
//
// Parameters
//   CYC_PER_MS : clock cycles per millisecond (>= 2)
//   DELAY_W    : width of delay / remaining
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   start      : request, sampled only in IDLE
//   delay      : delay count in selected unit, latched on accepted start
//   delay_unit : 0=ms 1=s 2=min 3=hr 4=day, 5..7 invalid
//   pause      : level, freezes counting while high
//   abort      : cancels an active delay (no done)
//   busy       : high in RUN and PAUSED
//   done       : one-cycle completion pulse
//   err        : one-cycle pulse for start with invalid unit
//   remaining  : units still to count, 0 when idle
// ---------------------------------------------------------------------------
module delay_timer_ctrl #(
   parameter int CYC_PER_MS = 100000,
   parameter int DELAY_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DELAY_W-1:0] delay,
   input  logic [2:0]         delay_unit,
   input  logic               pause,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DELAY_W-1:0] remaining
);

   localparam int               CYC_W   = $clog2(CYC_PER_MS);
   localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(CYC_PER_MS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q,   cyc_d;
   logic [9:0]         ms_q,    ms_d;
   logic [5:0]         sec_q,   sec_d;
   logic [5:0]         min_q,   min_d;
   logic [4:0]         hr_q,    hr_d;
   logic [DELAY_W-1:0] rem_q,   rem_d;
   logic [2:0]         unit_q,  unit_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;

   logic active;
   logic cnt_en;
   logic ms_tick, s_tick, min_tick, hr_tick, day_tick;
   logic unit_tick;

   assign active = (state_q != IDLE);

   // Counting is enabled on every active cycle where pause and abort are low.
   // This includes the PAUSED cycle in which pause is released, so the delay
   // is lengthened by exactly the number of cycles pause was sampled high.
   assign cnt_en = active && !pause && !abort;

   // Each tick is a strict AND with the tick below it. All units therefore
   // derive from the same cycle counter and cannot drift relative to one
   // another.
   assign ms_tick  = cnt_en   && (cyc_q == CYC_MAX);
   assign s_tick   = ms_tick  && (ms_q  == 10'd999);
   assign min_tick = s_tick   && (sec_q == 6'd59);
   assign hr_tick  = min_tick && (min_q == 6'd59);
   assign day_tick = hr_tick  && (hr_q  == 5'd23);

   always_comb begin
      unit_tick = 1'b0;
      case (unit_q)
         3'd0:    unit_tick = ms_tick;
         3'd1:    unit_tick = s_tick;
         3'd2:    unit_tick = min_tick;
         3'd3:    unit_tick = hr_tick;
         3'd4:    unit_tick = day_tick;
         default: unit_tick = 1'b0;
      endcase
   end

   // Next-state, prescaler and output logic
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      ms_d    = ms_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      rem_d   = rem_q;
      unit_d  = unit_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      // Prescaler chain. Each stage advances only on the tick below it, and
      // wraps to zero on the cycle it emits its own tick.
      if (cnt_en) begin
         cyc_d = ms_tick ? '0 : cyc_q + 1'b1;
         if (ms_tick)  ms_d  = s_tick   ? '0 : ms_q  + 10'd1;
         if (s_tick)   sec_d = min_tick ? '0 : sec_q + 6'd1;
         if (min_tick) min_d = hr_tick  ? '0 : min_q + 6'd1;
         if (hr_tick)  hr_d  = day_tick ? '0 : hr_q  + 5'd1;
      end

      case (state_q)
         IDLE: begin
            // abort is ignored here; a coincident start is accepted.
            if (start) begin
               if (delay_unit > 3'd4) begin
                  err_d = 1'b1;
               end else if (delay == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  rem_d   = delay;
                  unit_d  = delay_unit;
                  cyc_d   = '0;
                  ms_d    = '0;
                  sec_d   = '0;
                  min_d   = '0;
                  hr_d    = '0;
               end
            end
         end

         RUN, PAUSED: begin
            if (abort) begin
               // abort outranks both pause and a final unit tick.
               state_d = IDLE;
               rem_d   = '0;
               cyc_d   = '0;
               ms_d    = '0;
               sec_d   = '0;
               min_d   = '0;
               hr_d    = '0;
            end else if (pause) begin
               state_d = PAUSED;
            end else begin
               state_d = RUN;
               if (unit_tick) begin
                  if (rem_q == DELAY_W'(1)) begin
                     state_d = IDLE;
                     rem_d   = '0;
                     done_d  = 1'b1;
                     cyc_d   = '0;
                     ms_d    = '0;
                     sec_d   = '0;
                     min_d   = '0;
                     hr_d    = '0;
                  end else begin
                     rem_d = rem_q - 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
            rem_d   = '0;
            cyc_d   = '0;
            ms_d    = '0;
            sec_d   = '0;
            min_d   = '0;
            hr_d    = '0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         ms_q    <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         rem_q   <= '0;
         unit_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         ms_q    <= ms_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         rem_q   <= rem_d;
         unit_q  <= unit_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy      = active;
   assign done      = done_q;
   assign err       = err_q;
   assign remaining = rem_q;

endmodule

// File: tb/tb_delay_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_timer_ctrl
//
// Self-checking bench for delay_timer_ctrl with CYC_PER_MS = 4.
//
// Every start that should produce a done or err pulse pushes the cycle and
// kind of that pulse into exp_q. A negedge monitor pops and compares an
// entry each time the DUT pulses. Each scenario task checks busy and
// remaining inline, then confirms that no expected pulse is still pending.
// ---------------------------------------------------------------------------
module tb_delay_timer_ctrl;

   localparam int CPM = 4;
   localparam int DW  = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] delay;
   logic [2:0]    delay_unit;
   logic          pause;
   logic          abort;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] remaining;

   typedef struct {
      int cyc;
      bit is_err;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;

   delay_timer_ctrl #(
      .CYC_PER_MS(CPM),
      .DELAY_W   (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .delay     (delay),
      .delay_unit(delay_unit),
      .pause     (pause),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .remaining (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: each DUT pulse must match the oldest expectation.
   ev_t got;
   always @(negedge clk) begin
      if (!rst && (done || err)) begin
         n_tests++;
         if (done && err) begin
            n_fail++;
            $display("FAIL done_err_overlap cycle=%0d done=%0b err=%0b required=exclusive",
                     cyc, done, err);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cycle=%0d done=%0b err=%0b required=no pulse",
                     cyc, done, err);
         end else begin
            got = exp_q.pop_front();
            if (got.cyc !== cyc || got.is_err !== err) begin
               n_fail++;
               $display("FAIL pulse_timing got cycle=%0d err=%0b required cycle=%0d err=%0b",
                        cyc, err, got.cyc, got.is_err);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if ({busy, done, err} !== 3'b000 || remaining !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b rem=%0d required 0/0/0/0",
                  busy, done, err, remaining);
      end
      step(2);
      rst = 1'b0;
      step(1);
      n_tests++;
      if ({busy, done, err} !== 3'b000 || remaining !== '0) begin
         n_fail++;
         $display("FAIL post_reset_idle got busy=%0b done=%0b err=%0b rem=%0d required 0/0/0/0",
                  busy, done, err, remaining);
      end
   endtask

   // 3 ms at CPM=4: done 12 cycles after acceptance. The delay/unit inputs
   // change and a busy-time start is pulsed, and neither may disturb the run.
   task automatic test_ms();
      int acc;
      delay = 16'd3; delay_unit = 3'd0; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc + 12, is_err: 1'b0});
      step(1);
      start = 1'b0; delay = 16'hFFFF; delay_unit = 3'd7;
      n_tests++;
      if (busy !== 1'b1 || remaining !== 16'd3) begin
         n_fail++;
         $display("FAIL ms_accept got busy=%0b rem=%0d required busy=1 rem=3", busy, remaining);
      end
      start = 1'b1; delay = 16'd9;
      step(1);
      start = 1'b0;
      step(3);
      n_tests++;
      if (remaining !== 16'd2) begin
         n_fail++;
         $display("FAIL ms_rem2 got %0d required 2", remaining);
      end
      step(4);
      n_tests++;
      if (remaining !== 16'd1) begin
         n_fail++;
         $display("FAIL ms_rem1 got %0d required 1", remaining);
      end
      step(3);
      n_tests++;
      if (busy !== 1'b1 || remaining !== 16'd1) begin
         n_fail++;
         $display("FAIL ms_before_done got busy=%0b rem=%0d required busy=1 rem=1",
                  busy, remaining);
      end
      step(1);
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL ms_done_cycle got busy=%0b rem=%0d required busy=0 rem=0",
                  busy, remaining);
      end
      step(2);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL ms_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_sec();
      int acc;
      int t21;
      int t10;
      logic [DW-1:0] prev;
      t21 = -1;
      t10 = -1;
      delay = 16'd2; delay_unit = 3'd1; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc + 8000, is_err: 1'b0});
      step(1);
      start = 1'b0;
      prev = remaining;
      n_tests++;
      if (prev !== 16'd2) begin
         n_fail++;
         $display("FAIL sec_accept rem=%0d required 2", prev);
      end
      for (int i = 0; i < 8005; i++) begin
         step(1);
         if (remaining !== prev) begin
            if (prev == 16'd2 && remaining == 16'd1) t21 = cyc;
            if (prev == 16'd1 && remaining == 16'd0) t10 = cyc;
            prev = remaining;
         end
      end
      n_tests++;
      if (t21 !== acc + 4000) begin
         n_fail++;
         $display("FAIL sec_step_2to1 at cycle %0d required %0d", t21, acc + 4000);
      end
      n_tests++;
      if (t10 !== acc + 8000) begin
         n_fail++;
         $display("FAIL sec_step_1to0 at cycle %0d required %0d", t10, acc + 8000);
      end
      step(1);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sec_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_zero_err();
      int acc;
      delay = 16'd0; delay_unit = 3'd2; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc, is_err: 1'b0});
      step(1);
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_busy got %0b required 0", busy);
      end
      step(1);
      delay = 16'd5; delay_unit = 3'd6; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc, is_err: 1'b1});
      step(1);
      start = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL err_idle got busy=%0b rem=%0d required busy=0 rem=0", busy, remaining);
      end
      step(2);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL zero_err_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // pause sampled high on 10 edges stretches the 12-cycle delay to 22.
   task automatic test_pause();
      int acc;
      delay = 16'd3; delay_unit = 3'd0; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc + 22, is_err: 1'b0});
      step(1);
      start = 1'b0;
      step(5);
      pause = 1'b1;
      step(1);
      n_tests++;
      if (busy !== 1'b1 || remaining !== 16'd2) begin
         n_fail++;
         $display("FAIL pause_enter got busy=%0b rem=%0d required busy=1 rem=2", busy, remaining);
      end
      step(9);
      pause = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || remaining !== 16'd2) begin
         n_fail++;
         $display("FAIL pause_hold got busy=%0b rem=%0d required busy=1 rem=2", busy, remaining);
      end
      step(7);
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL pause_done got busy=%0b rem=%0d required busy=0 rem=0", busy, remaining);
      end
      step(2);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL pause_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      int acc;
      delay = 16'd3; delay_unit = 3'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(5);
      abort = 1'b1;
      step(1);
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_idle got busy=%0b rem=%0d required busy=0 rem=0", busy, remaining);
      end
      // Immediate restart, with abort still high in IDLE: the start is taken.
      delay = 16'd1; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc + 4, is_err: 1'b0});
      step(1);
      start = 1'b0; abort = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || remaining !== 16'd1) begin
         n_fail++;
         $display("FAIL abort_restart got busy=%0b rem=%0d required busy=1 rem=1", busy, remaining);
      end
      step(4);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_done busy=%0b required 0", busy);
      end
      // abort coincident with the final tick must suppress done.
      delay = 16'd1; start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_final got busy=%0b rem=%0d required busy=0 rem=0", busy, remaining);
      end
      step(3);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL abort_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_async_rst();
      int acc;
      delay = 16'd3; delay_unit = 3'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(3);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'd0) begin
         n_fail++;
         $display("FAIL async_rst got busy=%0b rem=%0d required busy=0 rem=0", busy, remaining);
      end
      step(1);
      rst = 1'b0;
      delay = 16'd1; delay_unit = 3'd0; start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{cyc: acc + CPM, is_err: 1'b0});
      step(1);
      start = 1'b0;
      step(CPM);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_restart_done busy=%0b required 0", busy);
      end
      step(2);
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rst_missing pending=%0d required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      delay      = '0;
      delay_unit = 3'd0;
      pause      = 1'b0;
      abort      = 1'b0;
      test_reset();
      test_ms();
      test_zero_err();
      test_pause();
      test_abort();
      test_async_rst();
      test_sec();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
